// File: rtl/ex_div.sv
// Iterative restoring divider for RV32M DIV/DIVU/REM/REMU in the EX stage.
// Holds the pipeline with stallreq while busy and abandons the operation on flush.
module ex_div #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             flush,
    output logic [WIDTH-1:0] result,
    output logic             done,
    output logic             stallreq
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t state_r;
    state_t state_next_s;

    logic             is_rem_r;
    logic             neg_q_r;
    logic             neg_r_r;
    logic [WIDTH-1:0] dvd_r;
    logic [WIDTH-1:0] dvs_r;
    logic [WIDTH:0]   rem_r;
    logic [CW-1:0]    count_r;
    logic [WIDTH-1:0] result_r;
    logic             done_r;

    logic             accept_s;
    logic             is_signed_s;
    logic             a_neg_s;
    logic             b_neg_s;
    logic             div_zero_s;
    logic             ovf_s;
    logic [WIDTH-1:0] special_res_s;
    logic [WIDTH+1:0] rem_shift_s;
    logic [WIDTH+1:0] diff_s;
    logic             q_bit_s;
    logic [WIDTH:0]   rem_next_s;
    logic [WIDTH-1:0] quo_next_s;
    logic [WIDTH-1:0] final_s;

    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
        return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    assign accept_s    = start & ~flush;
    assign is_signed_s = ~op[0];
    assign a_neg_s     = is_signed_s & dividend[WIDTH-1];
    assign b_neg_s     = is_signed_s & divisor[WIDTH-1];
    assign div_zero_s  = (divisor == {WIDTH{1'b0}});
    assign ovf_s       = is_signed_s & (dividend == {1'b1, {(WIDTH-1){1'b0}}})
                         & (divisor == {WIDTH{1'b1}});

    // Results that bypass the iteration: divide by zero and signed overflow
    always_comb begin
        special_res_s = {WIDTH{1'b0}};
        if (div_zero_s) begin
            special_res_s = op[1] ? dividend : {WIDTH{1'b1}};
        end else if (ovf_s) begin
            special_res_s = op[1] ? {WIDTH{1'b0}} : dividend;
        end else begin
            special_res_s = {WIDTH{1'b0}};
        end
    end

    // One restoring step; the extra top bit of the subtraction is the borrow
    assign rem_shift_s = {rem_r, dvd_r[WIDTH-1]};
    assign diff_s      = rem_shift_s - {2'b00, dvs_r};
    assign q_bit_s     = ~diff_s[WIDTH+1];
    assign rem_next_s  = q_bit_s ? diff_s[WIDTH:0] : rem_shift_s[WIDTH:0];
    assign quo_next_s  = {dvd_r[WIDTH-2:0], q_bit_s};

    // Sign fix-up of the last step's quotient or remainder
    always_comb begin
        final_s = {WIDTH{1'b0}};
        if (is_rem_r) begin
            final_s = neg_r_r ? negate(rem_next_s[WIDTH-1:0]) : rem_next_s[WIDTH-1:0];
        end else begin
            final_s = neg_q_r ? negate(quo_next_s) : quo_next_s;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; flush always wins
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_next_s = (div_zero_s | ovf_s) ? DONE : CALC;
                end else begin
                    state_next_s = IDLE;
                end
            end
            CALC: begin
                if (flush) begin
                    state_next_s = IDLE;
                end else if (count_r == LAST) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = CALC;
                end
            end
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Operand latch, iteration registers and registered result/done
    always_ff @(posedge clk) begin
        if (rst) begin
            is_rem_r <= 1'b0;
            neg_q_r  <= 1'b0;
            neg_r_r  <= 1'b0;
            dvd_r    <= {WIDTH{1'b0}};
            dvs_r    <= {WIDTH{1'b0}};
            rem_r    <= {(WIDTH+1){1'b0}};
            count_r  <= {CW{1'b0}};
            result_r <= {WIDTH{1'b0}};
            done_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        is_rem_r <= op[1];
                        neg_q_r  <= a_neg_s ^ b_neg_s;
                        neg_r_r  <= a_neg_s;
                        dvd_r    <= a_neg_s ? negate(dividend) : dividend;
                        dvs_r    <= b_neg_s ? negate(divisor) : divisor;
                        rem_r    <= {(WIDTH+1){1'b0}};
                        count_r  <= {CW{1'b0}};
                        if (div_zero_s | ovf_s) begin
                            result_r <= special_res_s;
                            done_r   <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    if (!flush) begin
                        rem_r   <= rem_next_s;
                        dvd_r   <= quo_next_s;
                        count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
                        if (count_r == LAST) begin
                            result_r <= final_s;
                            done_r   <= 1'b1;
                        end
                    end
                end
                DONE:    ;
                default: ;
            endcase
        end
    end

    assign result   = result_r;
    assign done     = done_r;
    assign stallreq = ~flush & (((state_r == IDLE) & start) | (state_r == CALC));

endmodule

// File: tb/tb_ex_div.sv
// Directed self-checking bench for ex_div: latency, stall window, signed rules,
// special cases, flush, mid-operation reset and back-to-back operation.
module tb_ex_div;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        flush;
    logic [31:0] result;
    logic        done;
    logic        stallreq;

    int pass_cnt;
    int total_cnt;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    ex_div #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .dividend (dividend),
        .divisor  (divisor),
        .flush    (flush),
        .result   (result),
        .done     (done),
        .stallreq (stallreq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one operation (start seen in cycle 0), scramble the operand inputs
    // afterwards, and report done cycle, stall-cycle count, result and stallreq at done.
    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         output int dc, output int sc, output logic [31:0] r, output logic sad);
        dc  = -1;
        sc  = 0;
        r   = 32'h0;
        sad = 1'b1;
        @(posedge clk); #1;
        op = o; dividend = a; divisor = b; start = 1'b1;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (stallreq) sc++;
            if (done) begin
                dc = c; r = result; sad = stallreq;
                break;
            end
            @(posedge clk); #1;
            op = ~o; dividend = ~a; divisor = b + 32'd3;
        end
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total_cnt++;
        if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else pass_cnt++;
        total_cnt++;
        if (result !== 32'h0) $display("FAIL reset_result: got %h want 0", result); else pass_cnt++;
        total_cnt++;
        if (stallreq !== 1'b0) $display("FAIL reset_stallreq: got %b want 0", stallreq); else pass_cnt++;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_normal();
        logic [1:0]  ops [7] = '{OP_DIVU, OP_REMU, OP_REM, OP_DIV, OP_DIV, OP_DIVU, OP_REM};
        logic [31:0] as  [7] = '{32'd100, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'd7, 32'd1000, 32'd7};
        logic [31:0] bs  [7] = '{32'd7, 32'd7, 32'd2, 32'd2, 32'hFFFFFFFE, 32'd10, 32'hFFFFFFFE};
        logic [31:0] exp [7] = '{32'd14, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFFD, 32'd100, 32'd1};
        int dc; int sc; logic [31:0] r; logic sad;
        for (int i = 0; i < 7; i++) begin
            do_op(ops[i], as[i], bs[i], dc, sc, r, sad);
            total_cnt++;
            if (dc !== 33 || sc !== 33 || sad !== 1'b0)
                $display("FAIL normal_timing[%0d]: done_cycle=%0d stall_cycles=%0d stall_at_done=%b want 33/33/0",
                         i, dc, sc, sad);
            else pass_cnt++;
            total_cnt++;
            if (r !== exp[i]) $display("FAIL normal_result[%0d]: got %h want %h", i, r, exp[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_special();
        logic [1:0]  ops [5] = '{OP_DIV, OP_REMU, OP_DIV, OP_REM, OP_DIVU};
        logic [31:0] as  [5] = '{32'd5, 32'h1234, 32'h80000000, 32'h80000000, 32'd77};
        logic [31:0] bs  [5] = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0};
        logic [31:0] exp [5] = '{32'hFFFFFFFF, 32'h1234, 32'h80000000, 32'h0, 32'hFFFFFFFF};
        int dc; int sc; logic [31:0] r; logic sad;
        for (int i = 0; i < 5; i++) begin
            do_op(ops[i], as[i], bs[i], dc, sc, r, sad);
            total_cnt++;
            if (dc !== 1 || sc !== 1 || sad !== 1'b0)
                $display("FAIL special_timing[%0d]: done_cycle=%0d stall_cycles=%0d stall_at_done=%b want 1/1/0",
                         i, dc, sc, sad);
            else pass_cnt++;
            total_cnt++;
            if (r !== exp[i]) $display("FAIL special_result[%0d]: got %h want %h", i, r, exp[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_flush();
        int seen;
        int dc; int sc; logic [31:0] r; logic sad;
        @(posedge clk); #1;
        op = OP_DIVU; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (stallreq !== 1'b0) $display("FAIL flush_stallreq_k: got %b want 0", stallreq); else pass_cnt++;
        @(posedge clk); #1;
        flush = 1'b0; start = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (stallreq !== 1'b0) $display("FAIL flush_idle_k1: stallreq got %b want 0", stallreq); else pass_cnt++;
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            if (done) seen++;
            @(negedge clk);
        end
        total_cnt++;
        if (seen !== 0) $display("FAIL flush_no_done: got %0d done pulses want 0", seen); else pass_cnt++;
        do_op(OP_DIVU, 32'd81, 32'd9, dc, sc, r, sad);
        total_cnt++;
        if (dc !== 33 || r !== 32'd9)
            $display("FAIL flush_recover: done_cycle=%0d result=%h want 33/00000009", dc, r);
        else pass_cnt++;
    endtask

    task automatic test_rst_mid();
        int seen;
        @(posedge clk); #1;
        op = OP_DIV; dividend = 32'hFFFFFF9C; divisor = 32'd7; start = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (done !== 1'b0 || result !== 32'h0 || stallreq !== 1'b0)
            $display("FAIL rst_mid_outputs: done=%b result=%h stallreq=%b want 0/00000000/0",
                     done, result, stallreq);
        else pass_cnt++;
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done) seen++;
        end
        total_cnt++;
        if (seen !== 0) $display("FAIL rst_mid_no_done: got %0d done pulses want 0", seen); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int dc1; int sc1; logic [31:0] r1; logic sad1;
        int dc2; int sc2; logic [31:0] r2; logic sad2;
        do_op(OP_DIVU, 32'hFFFFFFFF, 32'd1, dc1, sc1, r1, sad1);
        do_op(OP_DIVU, 32'd9, 32'd3, dc2, sc2, r2, sad2);
        total_cnt++;
        if (dc1 !== 33 || r1 !== 32'hFFFFFFFF)
            $display("FAIL b2b_first: done_cycle=%0d result=%h want 33/ffffffff", dc1, r1);
        else pass_cnt++;
        total_cnt++;
        if (dc1 + 2 + dc2 !== 68 || r2 !== 32'd3)
            $display("FAIL b2b_second: done_cycle=%0d result=%h want 68/00000003", dc1 + 2 + dc2, r2);
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt = 0; total_cnt = 0;
        rst = 1'b1; start = 1'b0; flush = 1'b0;
        op = 2'b00; dividend = 32'h0; divisor = 32'h0;
        test_reset();
        test_normal();
        test_special();
        test_flush();
        test_rst_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, passed %0d of %0d", pass_cnt, total_cnt);
        $fatal(1);
    end

endmodule

// File: doc/ex_div.md
# ex_div

Iterative 32-bit RV32M divider in the EX stage. It is the requesting end of the pipeline stall protocol. While a DIV/DIVU/REM/REMU is in flight it raises `stallreq` toward the pipeline controller, which freezes IF/ID/EX. It then drops the request in the cycle its result is valid. It also obeys the controller's flush by abandoning the operation.

## Interface
Parameters:
- `WIDTH`, default 32: operand and result width.

Ports:
- `clk`, in, 1: rising-edge clock.
- `rst`, in, 1: reset, synchronous, active-high.
- `start`, in, 1: EX holds a divide instruction; held high by the stalled pipeline until the result is consumed.
- `op`, in, 2: `00` DIV, `01` DIVU, `10` REM, `11` REMU.
- `dividend`, in, WIDTH: rs1 value.
- `divisor`, in, WIDTH: rs2 value.
- `flush`, in, 1: annul EX from the controller; aborts the current operation.
- `result`, out, WIDTH: quotient or remainder; valid only while `done` is 1.
- `done`, out, 1: result valid; high for exactly one cycle.
- `stallreq`, out, 1: stall request to the controller.

## Operation
- FSM states are IDLE, CALC and DONE. Reset state is IDLE.
- **IDLE**
  - If `start` is 1 and `flush` is 0, latch `op`, `dividend` and `divisor`.
  - Divisor = 0, or signed overflow (DIV/REM with dividend 0x80000000 and divisor 0xFFFFFFFF): precompute the result and go to DONE.
  - Otherwise load the iteration registers and go to CALC with count = 0.
- **CALC**
  - Run one restoring-division step per cycle on the magnitudes.
  - Partial remainder is WIDTH+1 bits. Shift left and bring in the next dividend MSB. Trial-subtract the divisor magnitude; if non-negative, keep the difference and shift in quotient bit 1, else shift in 0.
  - After WIDTH steps (count = WIDTH-1 on the last step), go to DONE.
- **DONE**
  - Drive `result` and assert `done`.
  - Return to IDLE on the next cycle unconditionally.
- **Sign rules** (DIV/REM only)
  - Operands are converted to magnitudes at latch time.
  - Quotient is negated when the operand signs differ.
  - Remainder takes the sign of the dividend.
  - DIVU and REMU use the raw operands.
- **Special results**
  - Divide by zero: quotient is 0xFFFFFFFF for both DIV and DIVU; remainder is the dividend unchanged.
  - Signed overflow: quotient is 0x80000000, remainder is 0.
- **Flush** in any state: go to IDLE next cycle, discard the latched operation, and produce no `done`. `flush` has priority over `start`.
- **`stallreq`** is combinational: `stallreq = ~flush & ((IDLE & start) | CALC)`. It is 0 in DONE, so the pipeline advances in the DONE cycle.
- Operand inputs are ignored after latching. Changes on `dividend`, `divisor` or `op` mid-operation have no effect.

## Timing
- **Reset values:** state = IDLE, `result` = 0, `done` = 0, `stallreq` = 0. Internal counters and registers are cleared.
- **Reset** asserted mid-CALC or in DONE: IDLE on the next edge, with no `done` pulse.
- **Normal latency:** `start` is seen in IDLE at cycle 0. CALC occupies cycles 1..32 and DONE is cycle 33.
  - `stallreq` is high for cycles 0..32 (33 cycles).
  - `done` and `result` are valid in cycle 33.
- **Special-case latency:** `stallreq` is high in cycle 0 only; `done` is in cycle 1.
- **Back-to-back divides:** DONE→IDLE, and a new `start` is accepted in the following cycle. There is one idle cycle between operations, in which `stallreq` rises again combinationally.
- **`result`** holds its last value outside DONE; consumers must qualify it with `done`.
- **Flush in cycle k:** `stallreq` goes low in cycle k (combinational). State is IDLE at k+1. If `start` is high at k+1, a fresh operation is latched.

## Test plan
- DIVU 100 / 7: `stallreq` high for cycles 0..32; at cycle 33, `done` = 1, `result` = 14, `stallreq` = 0. REMU on the same operands gives 2.
- Signed cases, each completing in cycle 33:
  - REM -7 % 2 gives 0xFFFFFFFF (-1).
  - DIV -7 / 2 gives 0xFFFFFFFD (-3).
  - DIV 7 / -2 gives 0xFFFFFFFD.
- Divide by zero, each with `done` in cycle 1 and `stallreq` high only in cycle 0:
  - DIV 5 / 0 gives 0xFFFFFFFF.
  - REMU 0x1234 / 0 gives 0x1234.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF gives 0x80000000 in cycle 1. REM on the same operands gives 0.
- Flush and reset:
  - `flush` in cycle 10 of a DIVU: `stallreq` is 0 in cycle 10, IDLE in cycle 11, and no `done` ever appears.
  - `rst` in cycle 20 of a DIV: all outputs 0 in cycle 21.
- Two back-to-back DIVU ops, 0xFFFFFFFF / 1 then 9 / 3: results 0xFFFFFFFF in cycle 33 and 3 in cycle 68. Latched operands are unaffected by input changes mid-operation.
